// File: rtl/bottle_spawn_scheduler.sv
// bottle_spawn_scheduler: sequences bottle respawns (collect count, cooldown, LFSR platform pick, spawn offer)
// Ports: clk, rst (async, active high); enable freezes cooldown/ignores collect when low;
//   tick (cooldown pulse), collect (diver hit live bottle), spawn_ready (consumer accepts);
//   spawn_valid/spawn_x/spawn_y (offered location), bottle_live (collect armed),
//   platform (0=A 1=B 2=C 3=start), score (saturating collect count).
module bottle_spawn_scheduler #(
  parameter logic [9:0] START_X       = 10'd296,
  parameter logic [9:0] START_Y       = 10'd364,
  parameter logic [9:0] PA_X          = 10'd70,
  parameter logic [9:0] PA_Y          = 10'd116,
  parameter logic [9:0] PB_X          = 10'd250,
  parameter logic [9:0] PB_Y          = 10'd116,
  parameter logic [9:0] PC_X          = 10'd430,
  parameter logic [9:0] PC_Y          = 10'd199,
  parameter int         RESPAWN_TICKS = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter logic [9:0] SCORE_MAX     = 10'd999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic       collect,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y,
  output logic       bottle_live,
  output logic [1:0] platform,
  output logic [9:0] score
);
  localparam int CW = (RESPAWN_TICKS == 0) ? 1 : $clog2(RESPAWN_TICKS + 1);
  // an all-zero seed would lock the LFSR
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  typedef enum logic [2:0] {S_INIT, S_OFFER, S_WAIT, S_DELAY, S_PICK} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_lfsr, w_lfsr;
  logic [1:0] w_raw, w_p;
  logic w_hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_INIT;
    else r_state <= w_next;
  always_comb begin
    w_hit  = (r_state == S_WAIT) && collect && enable;
    w_next = r_state == S_INIT  ? S_OFFER :
             r_state == S_OFFER ? (spawn_ready ? S_WAIT : S_OFFER) :
             r_state == S_WAIT  ? (w_hit ? S_DELAY : S_WAIT) :
             r_state == S_DELAY ? (r_cnt == '0 ? S_PICK : S_DELAY) :
             r_state == S_PICK  ? S_OFFER : S_INIT;
  end
  always_comb begin
    spawn_valid = r_state == S_OFFER;
    bottle_live = r_state == S_WAIT;
  end
  // Galois LFSR, x^8+x^6+x^5+x^4+1 in right-shift form
  always_comb begin
    w_lfsr = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    w_raw  = r_lfsr[1:0] == 2'd3 ? 2'd0 : r_lfsr[1:0];
    w_p    = w_raw == platform ? (w_raw == 2'd2 ? 2'd0 : w_raw + 2'd1) : w_raw;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      spawn_x  <= START_X;
      spawn_y  <= START_Y;
      platform <= 2'd3;
      score    <= '0;
      r_cnt    <= '0;
      r_lfsr   <= SEED;
    end else begin
      r_lfsr <= w_lfsr;
      // a tick coincident with the collect is dropped: the load wins
      if (w_hit) begin
        score <= score >= SCORE_MAX ? SCORE_MAX : score + 10'd1;
        r_cnt <= CW'(RESPAWN_TICKS);
      end else if (r_state == S_DELAY && r_cnt != '0 && tick && enable)
        r_cnt <= r_cnt - CW'(1);
      if (r_state == S_PICK) begin
        platform <= w_p;
        spawn_x  <= w_p == 2'd0 ? PA_X : w_p == 2'd1 ? PB_X : PC_X;
        spawn_y  <= w_p == 2'd0 ? PA_Y : w_p == 2'd1 ? PB_Y : PC_Y;
      end
    end
endmodule

// File: tb/tb_bottle_spawn_scheduler.sv
// tb_bottle_spawn_scheduler: scoreboard bench for the bottle respawn scheduler
module tb_bottle_spawn_scheduler;
  logic clk = 0, rst = 1, enable = 1, tick = 0, collect = 0, spawn_ready = 0;
  logic collect0 = 0, ready0 = 0;
  logic sv, bl, v0, bl0;
  logic [9:0] sx, sy, sc, x0, y0, sc0;
  logic [1:0] pl, pl0;
  logic [7:0] m_lfsr, m_prev;
  int errs = 0, checks = 0;
  int exp_score = 0, prev_plat = 3, seen = 0, e0 = 0;
  int q[$];
  always #5 clk = ~clk;
  bottle_spawn_scheduler #(.RESPAWN_TICKS(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .collect(collect),
    .spawn_ready(spawn_ready), .spawn_valid(sv), .spawn_x(sx), .spawn_y(sy),
    .bottle_live(bl), .platform(pl), .score(sc));
  bottle_spawn_scheduler #(.RESPAWN_TICKS(0)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .collect(collect0),
    .spawn_ready(ready0), .spawn_valid(v0), .spawn_x(x0), .spawn_y(y0),
    .bottle_live(bl0), .platform(pl0), .score(sc0));
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= (m_lfsr >> 1) ^ ({8{m_lfsr[0]}} & 8'hB8);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_collect;
    exp_score = exp_score < 999 ? exp_score + 1 : 999;
    q.push_back(exp_score);
    collect = 1;
    step();
    collect = 0;
  endtask
  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      step(gap);
      tick = 1;
      step();
      tick = 0;
    end
  endtask
  task automatic check_offer(input string tag);
    int p, es;
    p = int'(m_prev[1:0]);
    if (p == 3) p = 0;
    if (p == prev_plat) p = (p == 2) ? 0 : p + 1;
    check({tag, " valid"}, sv, 1);
    es = q.size() > 0 ? q.pop_front() : -1;
    check({tag, " score"}, sc, es);
    check({tag, " plat"}, pl, p);
    check({tag, " x"}, sx, p == 0 ? 70 : p == 1 ? 250 : 430);
    check({tag, " y"}, sy, p == 2 ? 199 : 116);
    check({tag, " norepeat"}, pl != prev_plat[1:0], 1);
    seen |= 1 << pl;
    prev_plat = p;
  endtask
  task automatic accept(input string tag, input int delay);
    logic [9:0] hx, hy;
    hx = sx;
    hy = sy;
    repeat (delay) step();
    check({tag, " hold valid"}, sv, 1);
    check({tag, " hold xy"}, {sx, sy}, {hx, hy});
    spawn_ready = 1;
    step();
    spawn_ready = 0;
    check({tag, " live"}, bl, 1);
    check({tag, " offer done"}, sv, 0);
  endtask
  task automatic respawn(input string tag, input int gap, input int delay);
    do_collect();
    check({tag, " delay live"}, bl, 0);
    ticks(4, gap);
    check({tag, " cool"}, sv, 0);
    step();
    check({tag, " pick"}, sv, 0);
    step();
    check_offer(tag);
    accept(tag, delay);
  endtask
  task automatic collect0_once;
    int n = 0;
    while (!bl0 && n < 10) begin
      step();
      n++;
    end
    if (n == 10) check("dut0 live timeout", bl0, 1);
    e0 = e0 < 999 ? e0 + 1 : 999;
    collect0 = 1;
    step();
    collect0 = 0;
  endtask
  initial begin
    ready0 = 1;
    step(2);
    check("rst valid", sv, 0);
    check("rst live", bl, 0);
    check("rst score", sc, 0);
    check("rst plat", pl, 3);
    check("rst xy", {sx, sy}, {10'd296, 10'd364});
    rst = 0;
    check("init valid", sv, 0);
    step();
    check("t1 valid", sv, 1);
    check("t1 xy", {sx, sy}, {10'd296, 10'd364});
    check("t1 plat", pl, 3);
    check("t1 live", bl, 0);
    accept("t1", 3);
    respawn("t2", 0, 10);
    for (int i = 0; i < 99; i++) respawn("t3", $urandom_range(0, 2), $urandom_range(0, 4));
    check("t3 all plats", seen, 7);
    check("t3 score", sc, 100);
    enable = 0;
    collect = 1;
    step();
    collect = 0;
    check("t4 dis live", bl, 1);
    check("t4 dis score", sc, 100);
    enable = 1;
    do_collect();
    collect = 1;
    step();
    collect = 0;
    check("t4 delay score", sc, 101);
    check("t4 delay live", bl, 0);
    enable = 0;
    ticks(3, 0);
    enable = 1;
    ticks(3, 0);
    step();
    check("t4 frozen a", sv, 0);
    step();
    check("t4 frozen b", sv, 0);
    ticks(1, 0);
    step();
    check("t4 pick", sv, 0);
    step();
    check_offer("t4");
    collect = 1;
    step();
    collect = 0;
    check("t4 offer score", sc, 101);
    check("t4 offer valid", sv, 1);
    accept("t4", 0);
    collect0 = 1;
    step();
    collect0 = 0;
    e0 = 1;
    check("t5 rt0 delay", v0, 0);
    step();
    check("t5 rt0 pick", v0, 0);
    step();
    check("t5 rt0 offer", v0, 1);
    step();
    check("t5 rt0 live", bl0, 1);
    check("t5 rt0 score", sc0, 1);
    for (int i = 1; i < 999; i++) collect0_once();
    check("t5 score max", sc0, e0);
    check("t5 score 999", sc0, 999);
    collect0_once();
    check("t5 sat score", sc0, 999);
    step(3);
    check("t5 sat respawn", bl0, 1);
    do_collect();
    ticks(2, 0);
    rst = 1;
    #1;
    check("t6 rst valid", sv, 0);
    check("t6 rst live", bl, 0);
    check("t6 rst score", sc, 0);
    check("t6 rst plat", pl, 3);
    q.delete();
    exp_score = 0;
    prev_plat = 3;
    step();
    rst = 0;
    check("t6 init", sv, 0);
    step();
    check("t6 valid", sv, 1);
    check("t6 xy", {sx, sy}, {10'd296, 10'd364});
    check("t6 score", sc, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
